ps2_host_tx: RTL



---
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, bit shifting on device clock, ACK check.
// Optional response/frame watchdogs are compiled in when PS2_HOST_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 10000,
    parameter int SETUP_CYC   = 100,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int FRAME_CYC   = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int FW = $clog2(FILTER_LEN) + 1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // index 0 = clock line, index 1 = data line
    logic [1:0]    meta_r, sync_r, filt_r, filt_nx_s;
    logic [FW-1:0] flt_cnt_r [2];
    logic [FW-1:0] flt_cnt_nx_s [2];
    logic          clk_filt_d_r, fall_evt_s;
    state_t        state_r, state_nx_s;
    logic [31:0]   timer_r, timer_nx_s;
    logic [3:0]    bit_cnt_r, bit_cnt_nx_s;
    logic [9:0]    shift_r, shift_nx_s;
    logic          clk_oe_nx_s, data_oe_nx_s, done_nx_s, err_nx_s, ready_nx_s;

    assign fall_evt_s = clk_filt_d_r & ~filt_r[0];

    // Glitch filter: a new level is taken only after FILTER_LEN consecutive differing samples
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_nx_s[i]    = filt_r[i];
            flt_cnt_nx_s[i] = {FW{1'b0}};
            if (sync_r[i] != filt_r[i]) begin
                if (flt_cnt_r[i] == FW'(FILTER_LEN - 1)) begin
                    filt_nx_s[i] = sync_r[i];
                end else begin
                    flt_cnt_nx_s[i] = flt_cnt_r[i] + {{(FW-1){1'b0}}, 1'b1};
                end
            end else begin
                flt_cnt_nx_s[i] = {FW{1'b0}};
            end
        end
    end

    // Line synchronizers and filter state
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r       <= 2'b00;
            sync_r       <= 2'b00;
            filt_r       <= 2'b00;
            clk_filt_d_r <= 1'b0;
            for (int i = 0; i < 2; i++) flt_cnt_r[i] <= {FW{1'b0}};
        end else begin
            meta_r       <= {ps2_data_i, ps2_clk_i};
            sync_r       <= meta_r;
            filt_r       <= filt_nx_s;
            clk_filt_d_r <= filt_r[0];
            for (int i = 0; i < 2; i++) flt_cnt_r[i] <= flt_cnt_nx_s[i];
        end
    end

    // Transfer FSM next state and next output levels
    always_comb begin
        state_nx_s   = state_r;
        timer_nx_s   = timer_r + 32'd1;
        bit_cnt_nx_s = bit_cnt_r;
        shift_nx_s   = shift_r;
        clk_oe_nx_s  = 1'b0;
        data_oe_nx_s = ps2_data_oe;
        case (state_r)
            ST_IDLE: begin
                data_oe_nx_s = 1'b0;
                timer_nx_s   = 32'd0;
                if (tx_valid && tx_ready) begin
                    state_nx_s  = ST_INHIBIT;
                    shift_nx_s  = {1'b1, odd_parity(tx_data), tx_data};
                    clk_oe_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                clk_oe_nx_s = 1'b1;
                if (timer_r == 32'(INHIBIT_CYC - 1)) begin
                    state_nx_s   = ST_START;
                    data_oe_nx_s = 1'b1;
                    timer_nx_s   = 32'd0;
                end else begin
                    state_nx_s = ST_INHIBIT;
                end
            end
            ST_START: begin
                clk_oe_nx_s  = 1'b1;
                data_oe_nx_s = 1'b1;
                if (timer_r == 32'(SETUP_CYC - 1)) begin
                    state_nx_s   = ST_DATA;
                    clk_oe_nx_s  = 1'b0;
                    timer_nx_s   = 32'd0;
                    bit_cnt_nx_s = 4'd0;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (fall_evt_s) begin
                    data_oe_nx_s = ~shift_r[0];
                    shift_nx_s   = {1'b0, shift_r[9:1]};
                    bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    // the frame watchdog starts at the first device edge
                    if (bit_cnt_r == 4'd0) begin
                        timer_nx_s = 32'd0;
                    end else begin
                        timer_nx_s = timer_r + 32'd1;
                    end
                    if (bit_cnt_r == 4'd9) begin
                        state_nx_s = ST_ACK;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else if (WDOG_EN && (bit_cnt_r == 4'd0) && (timer_r == 32'(TIMEOUT_CYC - 1))) begin
                    state_nx_s   = ST_ERR;
                    data_oe_nx_s = 1'b0;
                end else if (WDOG_EN && (bit_cnt_r != 4'd0) && (timer_r == 32'(FRAME_CYC - 1))) begin
                    state_nx_s   = ST_ERR;
                    data_oe_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_ACK: begin
                data_oe_nx_s = 1'b0;
                if (fall_evt_s) begin
                    if (filt_r[1] == 1'b0) begin
                        state_nx_s = ST_RELEASE;
                    end else begin
                        state_nx_s = ST_ERR;
                    end
                end else if (WDOG_EN && (timer_r == 32'(FRAME_CYC - 1))) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_ACK;
                end
            end
            ST_RELEASE: begin
                data_oe_nx_s = 1'b0;
                if (filt_r == 2'b11) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RELEASE;
                end
            end
            ST_ERR: begin
                data_oe_nx_s = 1'b0;
                state_nx_s   = ST_IDLE;
            end
            default: begin
                data_oe_nx_s = 1'b0;
                state_nx_s   = ST_IDLE;
            end
        endcase
        done_nx_s  = (state_r == ST_RELEASE) && (state_nx_s == ST_IDLE);
        err_nx_s   = (state_nx_s == ST_ERR);
        ready_nx_s = (state_nx_s == ST_IDLE) && (filt_nx_s == 2'b11);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            timer_r     <= 32'd0;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 10'd0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            timer_r     <= timer_nx_s;
            bit_cnt_r   <= bit_cnt_nx_s;
            shift_r     <= shift_nx_s;
            ps2_clk_oe  <= clk_oe_nx_s;
            ps2_data_oe <= data_oe_nx_s;
            tx_done     <= done_nx_s;
            tx_err      <= err_nx_s;
            tx_ready    <= ready_nx_s;
            busy        <= ~ready_nx_s;
        end
    end
endmodule
